// File: rtl/systolic_deskew_collector.sv
// systolic_deskew_collector
// Bottom-row collector for the 4x4 systolic array. It deskews the four column
// outputs, packs each aligned row into a 4-lane word and buffers the words in a
// first-word-fall-through FIFO. The FIFO drains through a valid/ready stream.
// Build option: define COLLECTOR_RELU_EN to clamp negative lanes to 0 at push.

// Per-column delay line. Column j needs (3-j) stages so that all columns of a
// row line up in the same cycle. A zero-stage lane is a plain wire.
module sdc_lane #(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  en_d,
   output logic [DATA_WIDTH-1:0] data_d
);
   generate
      if (STAGES == 0) begin : g_comb
         logic unused;
         assign unused = &{1'b0, clk, rst_n, clr};
         assign en_d   = en;
         assign data_d = data;
      end else begin : g_pipe
         logic [STAGES:1]                 vld_pipe;
         logic [STAGES:1][DATA_WIDTH-1:0] dat_pipe;

         // shift valid and data one stage per cycle; clear drops partial rows
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_pipe <= '0;
               dat_pipe <= '0;
            end else if (clr) begin
               vld_pipe <= '0;
               dat_pipe <= '0;
            end else begin
               vld_pipe[1] <= en;
               dat_pipe[1] <= data;
               for (int i = 2; i <= STAGES; i++) begin
                  vld_pipe[i] <= vld_pipe[i-1];
                  dat_pipe[i] <= dat_pipe[i-1];
               end
            end
         end

         assign en_d   = vld_pipe[STAGES];
         assign data_d = dat_pipe[STAGES];
      end
   endgenerate
endmodule

module systolic_deskew_collector #(
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 8,
   parameter int ROWS_PER_TILE = 4
) (
   input  logic                            col_clk,
   input  logic                            col_rst_n,
   input  logic                            col_clear,
   input  logic                            col_en_0,
   input  logic                            col_en_1,
   input  logic                            col_en_2,
   input  logic                            col_en_3,
   input  logic [DATA_WIDTH-1:0]           col_data_0,
   input  logic [DATA_WIDTH-1:0]           col_data_1,
   input  logic [DATA_WIDTH-1:0]           col_data_2,
   input  logic [DATA_WIDTH-1:0]           col_data_3,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [4*DATA_WIDTH-1:0]         out_data,
   output logic                            out_last,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] out_count,
   output logic                            err_misalign,
   output logic                            err_overflow
);
   localparam int NUM_LANES = 4;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int RW = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;

   typedef struct packed {
      logic                                 last;
      logic [NUM_LANES-1:0][DATA_WIDTH-1:0] data;
   } word_t;

   logic [NUM_LANES-1:0]                 col_en, en_d;
   logic [NUM_LANES-1:0][DATA_WIDTH-1:0] col_data, data_d, lane_val;

   assign col_en   = {col_en_3, col_en_2, col_en_1, col_en_0};
   assign col_data = {col_data_3, col_data_2, col_data_1, col_data_0};

   generate
      for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
         sdc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .STAGES     (NUM_LANES-1-j)
         ) u_lane (
            .clk    (col_clk),
            .rst_n  (col_rst_n),
            .clr    (col_clear),
            .en     (col_en[j]),
            .data   (col_data[j]),
            .en_d   (en_d[j]),
            .data_d (data_d[j])
         );
`ifdef COLLECTOR_RELU_EN
         assign lane_val[j] = data_d[j][DATA_WIDTH-1] ? '0 : data_d[j];
`else
         assign lane_val[j] = data_d[j];
`endif
      end
   endgenerate

   word_t            mem [FIFO_DEPTH];
   word_t            wr_word;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic [RW-1:0]    row_cnt;
   logic             aligned, misalign, full, pop, push, drop, tile_end;

   assign aligned  = &en_d;
   assign misalign = (|en_d) && !aligned;
   assign full     = (count == CW'(FIFO_DEPTH));
   assign pop      = out_valid && out_ready;
   // a full FIFO still takes the word when the head leaves in the same cycle
   assign push     = aligned && (!full || pop);
   assign drop     = aligned && full && !pop;
   assign tile_end = (row_cnt == RW'(ROWS_PER_TILE-1));

   assign wr_word.last = tile_end;
   assign wr_word.data = lane_val;

   // word storage needs no reset: the head is masked whenever the FIFO is empty
   always_ff @(posedge col_clk) begin
      if (push && !col_clear) mem[wr_ptr] <= wr_word;
   end

   // pointers, occupancy, tile row counter and sticky error flags
   always_ff @(posedge col_clk or negedge col_rst_n) begin
      if (!col_rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         row_cnt      <= '0;
         err_misalign <= 1'b0;
         err_overflow <= 1'b0;
      end else if (col_clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         row_cnt      <= '0;
         err_misalign <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr  <= wr_ptr + AW'(1);
            row_cnt <= tile_end ? '0 : row_cnt + RW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (misalign) err_misalign <= 1'b1;
         if (drop)     err_overflow <= 1'b1;
      end
   end

   assign out_valid = (count != '0);
   assign out_count = count;
   assign out_data  = out_valid ? mem[rd_ptr].data : '0;
   assign out_last  = out_valid && mem[rd_ptr].last;
endmodule

// File: doc/systolic_deskew_collector.md
# systolic_deskew_collector

Downstream stage of the 4x4 systolic array: captures the four bottom-row outputs (`array_en_down_3_*` / `array_data_down_3_*`) and removes the one-cycle-per-column skew. It assembles each result row into a single 4-lane word and buffers it in a FIFO, because the array cannot stall. Words leave through a valid/ready stream toward the NICE writeback path. Tile boundaries are marked with `out_last`, and misalignment and overflow are reported through sticky error flags.

## Interface
- `DATA_WIDTH`, 32, lane width; must match the array's `DATA_WIDTH`.
- `FIFO_DEPTH`, 8, result words buffered; power of two, ≥2.
- `ROWS_PER_TILE`, 4, words per tile; `out_last` is asserted on the last word of each tile.
- `col_clk`  in  1  single clock, shared with `array_clk`.
- `col_rst_n`  in  1  asynchronous, active-low reset.
- `col_clear`  in  1  synchronous clear of all state; has priority over every other input.
- `col_en_0..col_en_3`  in  1 each  column valid bits from the array's bottom row.
- `col_data_0..col_data_3`  in  DATA_WIDTH each  column results (signed two's complement).
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  4*DATA_WIDTH  lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- `out_last`  out  1  word is the final row of a tile.
- `out_count`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- `err_misalign`  out  1  sticky flag.
- `err_overflow`  out  1  sticky flag.

## Operation
- **Deskew.** Column j data and en pass through a (3−j)-stage register delay line:
  - column 0: 3 stages; column 1: 2; column 2: 1; column 3: combinational (0 stages).
  - Delay-line registers reset and clear to 0.
- **Aligned event.** All four deskewed en bits high.
  - Forms a word with lane j = deskewed `col_data_j` (after the optional ReLU).
  - Pushes the word into the FIFO.
- **Misalignment.** One to three of the deskewed en bits high.
  - Sets `err_misalign`.
  - Writes no word and does not advance the row counter.
- **Row counter.** Counts 0..ROWS_PER_TILE−1 and increments on each accepted push.
  - The `out_last` tag is stored with the word when the counter equals ROWS_PER_TILE−1.
  - The counter wraps to 0 on that push.
- **FIFO full.** A push is accepted only if the FIFO is not full, or a pop occurs in the same cycle.
  - Otherwise the word is dropped and `err_overflow` is set.
  - A dropped word does not advance the row counter.
- **Pop.** Occurs on `out_valid && out_ready`.
  - Simultaneous push and pop leaves `out_count` unchanged.
  - Pop with `out_ready` while empty is ignored.
- **Stream rules.** `out_data` and `out_last` are stable while `out_valid && !out_ready`. `out_valid` never deasserts without a pop.
- **Error flags.** Cleared only by reset or `col_clear`.
- **`col_clear`.** Empties the FIFO, zeroes the delay lines, row counter and error flags, and drops any in-flight partial row.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_last`=0, `out_count`=0, `err_misalign`=0, `err_overflow`=0.
- **Arrival pattern:** `col_en_0` high at cycle t means `col_en_j` is expected at cycle t+j. The aligned event occurs at cycle t+3.
- **Push:** registered at the edge ending cycle t+3.
- **Output latency:** with an empty FIFO, `out_valid`=1 and `out_data` present in cycle t+4. Latency is 1 cycle after column 3 arrives, 4 cycles after column 0.
- **Output source:** `out_data` is driven from the FIFO head register (first-word fall-through) with no combinational path from `col_*` to `out_*`.
- **Throughput:** one word per cycle sustained, in both directions.
- **Error flags:** rise in the cycle after the offending event.
- **Asynchronous reset mid-row:** all partial data is discarded immediately.

## Configuration
- **`COLLECTOR_RELU_EN` defined:** each lane is clamped at push time; any value with MSB=1 is written as 0, otherwise unchanged. Adds no latency.
- **Undefined:** lanes pass unmodified.
- The misalignment, overflow and `out_last` logic are identical in both builds.

## Test plan
- **Basic deskew:** drive row (1,2,3,4) with `col_en_j`/`col_data_j` at cycles 0..3, `out_ready`=1.
  - `out_valid` in cycle 4 only, `out_data`={4,3,2,1} (lane 3 MSB), `out_count` pulses 1.
- **Tile tagging:** 8 back-to-back skewed rows, ROWS_PER_TILE=4, `out_ready`=1.
  - 8 consecutive words; `out_last`=1 on words 4 and 8 only.
- **Backpressure / overflow:** `out_ready`=0, push 9 rows, FIFO_DEPTH=8.
  - `out_count`=8, `err_overflow`=1 after row 9, ninth word absent.
  - Then raise `out_ready`: exactly 8 words drain in order.
- **Misalignment:** `col_en_0` at cycle 0, `col_en_1..3` never asserted.
  - `err_misalign`=1 at cycle 4, `out_valid` stays 0, row counter unchanged.
  - `col_clear` then zeroes the flag.
- **Full with simultaneous pop:** FIFO at 8, `out_ready`=1 and an aligned push in the same cycle.
  - Word accepted, `out_count` stays 8, `err_overflow` stays 0.
- **ReLU build:** with `COLLECTOR_RELU_EN`, row (−5, 7, 0x80000000, 0).
  - Word {0, 0, 7, 0}. Without the macro: {0, 0x80000000, 7, 0xFFFFFFFB}.
